// File: rtl/pilots_remove_if.sv
// pilots_remove_if: WISHBONE-style pipelined stream bundle.
// The master side drives dat/cyc/stb/we and receives ack; the slave side
// receives dat/cyc/stb/we and drives ack.
interface pilots_remove_if #(
    parameter int DW = 32
);
    logic [DW-1:0] dat;
    logic          cyc;
    logic          stb;
    logic          we;
    logic          ack;

    modport master (output dat, output cyc, output stb, output we, input ack);
    modport slave  (input dat, input cyc, input stb, input we, output ack);
endinterface

// File: rtl/pilots_remove.sv
// pilots_remove: receive-side pilot / null-carrier removal.
// Walks the 2-bit allocation map carrier by carrier, forwards data carriers
// (code 10) downstream and drops nulls (00) and pilots (01 / 11).
// Optional macro PILOTS_REMOVE_PIL_OUT_EN exports sign-corrected pilots on
// PIL_DAT_O / PIL_STB_O; without it those outputs are tied to zero.
module pilots_remove #(
    parameter int P_W = 16
) (
    input  logic                CLK_I,
    input  logic                RST_I,
    pilots_remove_if.slave      in_bus,
    pilots_remove_if.master     out_bus,
    input  logic [1:0]          STD,
    input  logic [4095:0]       ALLOC_VEC,
    output logic                VEC_LD,
    output logic [2*P_W-1:0]    PIL_DAT_O,
    output logic                PIL_STB_O
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_RUN   = 2'd2,
        S_FLUSH = 2'd3
    } state_t;

    state_t              state_r;
    state_t              state_s;
    logic [10:0]         car_cnt_r;
    logic [4095:0]       alloc_r;
    logic [2*P_W-1:0]    dat_o_r;
    logic                stb_o_r;
    logic                cyc_o_r;
    logic [10:0]         n_last_s;
    logic                out_halt_s;
    logic                ack_s;
    logic                vec_ld_s;
    logic                last_s;
    logic [1:0]          code_s;

    // The code of the carrier being offered sits at the bottom of the shift register
    assign code_s     = alloc_r[1:0];
    assign out_halt_s = stb_o_r & ~out_bus.ack;
    assign last_s     = (car_cnt_r == n_last_s);

    // Index of the last carrier of a symbol for the selected standard
    always_comb begin
        case (STD)
            2'b00:   n_last_s = 11'd63;
            2'b01:   n_last_s = 11'd255;
            2'b10:   n_last_s = 11'd2047;
            default: n_last_s = 11'd2047;
        endcase
    end

    // Next-state decode, input acknowledge and map-load request
    always_comb begin
        state_s  = state_r;
        ack_s    = 1'b0;
        vec_ld_s = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (in_bus.cyc && (STD != 2'b11)) begin
                    state_s = S_LOAD;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_LOAD: begin
                vec_ld_s = 1'b1;
                state_s  = S_RUN;
            end
            S_RUN: begin
                ack_s = in_bus.cyc & in_bus.stb & in_bus.we & ~out_halt_s;
                if (!in_bus.cyc) begin
                    state_s = S_FLUSH;
                end else if (ack_s && last_s) begin
                    state_s = S_LOAD;
                end else begin
                    state_s = S_RUN;
                end
            end
            S_FLUSH: begin
                if (!stb_o_r) begin
                    state_s = S_IDLE;
                end else begin
                    state_s = S_FLUSH;
                end
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // State register, carrier counter and allocation shift register
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state_r   <= S_IDLE;
            car_cnt_r <= 11'd0;
            alloc_r   <= {4096{1'b0}};
        end else begin
            state_r <= state_s;
            if (state_r == S_LOAD) begin
                alloc_r   <= ALLOC_VEC;
                car_cnt_r <= 11'd0;
            end else if (ack_s) begin
                alloc_r   <= {2'b00, alloc_r[4095:2]};
                car_cnt_r <= last_s ? 11'd0 : (car_cnt_r + 11'd1);
            end
        end
    end

    // Data-carrier output register; holds under back-pressure, CYC_O drops only once drained
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            dat_o_r <= {(2*P_W){1'b0}};
            stb_o_r <= 1'b0;
            cyc_o_r <= 1'b0;
        end else begin
            if (ack_s && (code_s == 2'b10)) begin
                dat_o_r <= in_bus.dat;
                stb_o_r <= 1'b1;
                cyc_o_r <= 1'b1;
            end else if (out_bus.ack) begin
                stb_o_r <= 1'b0;
            end
            if ((state_r == S_FLUSH) && !stb_o_r) begin
                cyc_o_r <= 1'b0;
            end
        end
    end

    assign in_bus.ack  = ack_s;
    assign VEC_LD      = vec_ld_s;
    assign out_bus.dat = dat_o_r;
    assign out_bus.stb = stb_o_r;
    assign out_bus.cyc = cyc_o_r;
    assign out_bus.we  = stb_o_r;

`ifdef PILOTS_REMOVE_PIL_OUT_EN
    logic [2*P_W-1:0] pil_dat_r;
    logic             pil_stb_r;

    // Two's complement negation; the most negative value saturates to the most positive
    function automatic logic [P_W-1:0] sat_neg(input logic [P_W-1:0] x);
        if (x == {1'b1, {(P_W-1){1'b0}}}) begin
            sat_neg = {1'b0, {(P_W-1){1'b1}}};
        end else begin
            sat_neg = ~x + {{(P_W-1){1'b0}}, 1'b1};
        end
    endfunction

    // Pilot export: one-cycle strobe, value held until the next pilot
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            pil_dat_r <= {(2*P_W){1'b0}};
            pil_stb_r <= 1'b0;
        end else begin
            pil_stb_r <= 1'b0;
            if (ack_s && (code_s == 2'b01)) begin
                pil_dat_r <= in_bus.dat;
                pil_stb_r <= 1'b1;
            end else if (ack_s && (code_s == 2'b11)) begin
                pil_dat_r <= {sat_neg(in_bus.dat[2*P_W-1:P_W]), sat_neg(in_bus.dat[P_W-1:0])};
                pil_stb_r <= 1'b1;
            end
        end
    end

    assign PIL_DAT_O = pil_dat_r;
    assign PIL_STB_O = pil_stb_r;
`else
    assign PIL_DAT_O = {(2*P_W){1'b0}};
    assign PIL_STB_O = 1'b0;
`endif

endmodule

// File: doc/pilots_remove.md
Name: pilots_remove

Overview:
- Receive-side counterpart of the transmit pilot/null-carrier insertion stage.
- Consumes one frequency-domain sample per subcarrier, in natural carrier order, on a WISHBONE-style pipelined stream.
- Uses the 2-bit-per-carrier allocation vector to discard null carriers and pilots, and forwards only data carriers downstream to the demapper.
- Optionally exports sign-corrected pilot samples for channel estimation.

Parameters:
- P_W, 16, width of each I/Q component; DAT is {Q[31:16], I[15:0]}, two's complement Q1.15.

Ports:
- CLK_I  in  1  clock; single clock domain.
- RST_I  in  1  reset; synchronous, active-high.
- DAT_I  in  32  input carrier sample {Q,I}.
- CYC_I  in  1  input cycle; high for the whole stream of symbols.
- STB_I  in  1  input strobe.
- WE_I  in  1  input write enable; must be 1 for a transfer.
- ACK_O  out  1  input acknowledge; a sample is accepted when CYC_I&STB_I&WE_I&ACK_O.
- DAT_O  out  32  data-carrier sample out.
- CYC_O  out  1  output cycle.
- STB_O  out  1  output strobe.
- WE_O  out  1  equals STB_O.
- ACK_I  in  1  downstream acknowledge.
- STD  in  2  00: 64 carriers; 01: 256; 10: 2048; 11: reserved.
- ALLOC_VEC  in  4096  carrier map, 2 bits per carrier, carrier k at bits [2k+1:2k]. Codes: 00 null, 01 +pilot, 11 -pilot, 10 data.
- VEC_LD  out  1  one-cycle request; ALLOC_VEC must be valid in that same cycle and is captured on that edge.
- PIL_DAT_O  out  32  sign-corrected pilot (optional feature).
- PIL_STB_O  out  1  pilot valid pulse (optional feature).

Behaviour:
- Reset values: all outputs 0; state IDLE; carrier counter 0; alloc shift register 0.
- Number of carriers N per symbol = 64 / 256 / 2048 from STD. STD=11: block stays in IDLE, ACK_O=0.
- State machine:
  - IDLE: ACK_O=0. On CYC_I=1 go to LOAD.
  - LOAD: VEC_LD=1 for exactly one cycle; alloc_reg<=ALLOC_VEC; car_cnt<=0; go to RUN. ACK_O=0 in LOAD.
  - RUN: ACK_O = CYC_I & STB_I & WE_I & ~out_halt, where out_halt = STB_O & ~ACK_I.
    - Each accept: car_cnt+1; alloc_reg shifts right by 2 (zero fill); the current code is alloc_reg[1:0].
    - Accepting carrier N-1 goes to LOAD, giving a one-cycle ACK_O bubble between symbols.
    - CYC_I=0 in RUN (including mid-symbol) goes to FLUSH; any partial symbol is abandoned.
  - FLUSH: ACK_O=0; wait until STB_O=0, then CYC_O<=0 and go to IDLE.
- Data path:
  - Code 10 on accept: DAT_O<=DAT_I and STB_O<=1 on the next edge (1-cycle latency).
  - Codes 00/01/11: sample is consumed and dropped; STB_O is not set by it.
  - STB_O and DAT_O are held stable while ACK_I=0.
  - STB_O falls after ACK_I unless a new data carrier is accepted in the same cycle. Back-to-back data then streams at 1 per clock with no bubble.
  - DAT_O changes only when loading a new data carrier.
- CYC_O rises with the first STB_O after leaving IDLE, stays high across symbols, and falls only from FLUSH.
- Boundary rules:
  - Carrier count wraps only via LOAD; it never exceeds N-1.
  - A symbol containing no data carriers produces no STB_O.
  - RST_I mid-symbol clears everything at that edge. The next CYC_I restarts at carrier 0 with a fresh VEC_LD.

Optional Feature:
- Macro PILOTS_REMOVE_PIL_OUT_EN.
- When defined: on accepting a pilot code, PIL_STB_O=1 for one cycle on the next edge. PIL_DAT_O holds DAT_I for code 01, or component-wise negation for code 11. Negating -32768 (16'h8000) saturates to 16'h7fff. PIL_DAT_O holds until the next pilot. There is no pilot back-pressure.
- When undefined: PIL_DAT_O=0 and PIL_STB_O=0 constantly; no pilot logic is synthesized.

Test Plan:
- STD=00; map: carriers 0-3 null, 4 +pilot, 5-62 data, 63 null. Feed DAT_I=carrier index with ACK_I=1 -> exactly 58 STB_O beats, DAT_O=5..62 in order. VEC_LD pulses once before carrier 0 and once after carrier 63 is accepted.
- Same stream with ACK_I toggling 1,0,0,1 -> no data lost or duplicated; DAT_O stable while ACK_I=0; ACK_O=0 whenever STB_O=1 and ACK_I=0.
- Map with carrier 7 = 11 and DAT_I=32'h4000_8000, macro defined -> PIL_STB_O pulse with PIL_DAT_O=32'hC000_7FFF. Without the macro, PIL_STB_O stays 0.
- STD=01, two back-to-back symbols with an all-data map -> 512 outputs, exactly one idle ACK_O cycle between symbols, CYC_O never drops.
- Drop CYC_I after carrier 20 -> pending DAT_O drained, CYC_O falls, state IDLE. Next CYC_I produces a VEC_LD and restarts at carrier 0.
- Assert RST_I while STB_O=1 -> next cycle STB_O=0, CYC_O=0, DAT_O=0, VEC_LD=0.
